// File: rtl/priority_grant_scheduler_pkg.sv
// Shared types and constants for the priority grant scheduler:
// FSM encoding, default hold time, 7-segment table and winner selection.
package priority_grant_scheduler_pkg;

  typedef enum logic [1:0] {
    ST_IDLE    = 2'd0,
    ST_GRANT   = 2'd1,
    ST_RELEASE = 2'd2
  } state_t;

  localparam int unsigned HOLD_CYCLES_DEFAULT = 4;

  // gfedcba codes, element i is the pattern for digit i
  localparam logic [7:0][6:0] SEG_TABLE = {
    7'b0000111,  // 7
    7'b1111101,  // 6
    7'b1101101,  // 5
    7'b1100110,  // 4
    7'b1001111,  // 3
    7'b1011011,  // 2
    7'b0000110,  // 1
    7'b0111111   // 0
  };

  // Fixed mode: highest set index. Round-robin: first set index at or above ptr, wrapping.
  function automatic logic [2:0] pick_winner(input logic [7:0] pend,
                                             input logic       rr,
                                             input logic [2:0] ptr);
    logic [2:0] w;
    logic [2:0] j;
    logic       found;
    w     = '0;
    j     = '0;
    found = 1'b0;
    if (!rr) begin
      for (int unsigned i = 0; i < 8; i++) begin
        if (pend[i]) w = 3'(i);
      end
    end else begin
      for (int unsigned k = 0; k < 8; k++) begin
        j = ptr + 3'(k);
        if (!found && pend[j]) begin
          w     = j;
          found = 1'b1;
        end
      end
    end
    return w;
  endfunction

endpackage

// File: rtl/priority_grant_scheduler_if.sv
// Request/grant bundle between requesters (master) and the scheduler (slave).
interface priority_grant_scheduler_if;
  logic [7:0] req;
  logic       rr_mode;
  logic [7:0] grant;
  logic       grant_valid;
  logic [7:0] ack;
  logic [6:0] segments;
  logic       none;

  modport master (
    output req, rr_mode,
    input  grant, grant_valid, ack, segments, none
  );

  modport slave (
    input  req, rr_mode,
    output grant, grant_valid, ack, segments, none
  );
endinterface

// File: rtl/digit_to_7seg.sv
// Combinational 3-bit index to 7-segment (gfedcba) decoder.
module digit_to_7seg
  import priority_grant_scheduler_pkg::*;
(
  input  logic [2:0] digit,
  output logic [6:0] segments
);
  assign segments = SEG_TABLE[digit];
endmodule

// File: rtl/priority_grant_scheduler.sv
// Eight-way request scheduler: latches requests into a pending set, grants one
// index for HOLD_CYCLES, then acks it for one cycle before re-arbitrating.
module priority_grant_scheduler
  import priority_grant_scheduler_pkg::*;
#(
  parameter int unsigned HOLD_CYCLES = HOLD_CYCLES_DEFAULT
) (
  input  logic                          clk,
  input  logic                          rst,
  priority_grant_scheduler_if.slave     bus
);

  state_t     state;
  logic [7:0] pending;
  logic [2:0] rr_ptr;
  logic [2:0] idx;
  logic [7:0] cnt;
  logic [7:0] grant_q;
  logic       gv_q;
  logic [7:0] ack_q;
  logic [2:0] winner;
  logic [6:0] seg_raw;

  always_comb begin
    winner = '0;
    winner = pick_winner(pending, bus.rr_mode, rr_ptr);
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state   <= ST_IDLE;
      pending <= '0;
      rr_ptr  <= '0;
      idx     <= '0;
      cnt     <= '0;
      grant_q <= '0;
      gv_q    <= 1'b0;
      ack_q   <= '0;
    end else begin
      ack_q <= '0;
      unique case (state)
        ST_IDLE: begin
          pending <= pending | bus.req;
          if (pending != '0) begin
            idx     <= winner;
            cnt     <= 8'(HOLD_CYCLES);
            grant_q <= 8'b1 << winner;
            gv_q    <= 1'b1;
            state   <= ST_GRANT;
          end
        end
        ST_GRANT: begin
          pending <= pending | bus.req;
          cnt     <= cnt - 8'd1;
          if (cnt == 8'd1) begin
            grant_q <= '0;
            gv_q    <= 1'b0;
            ack_q   <= 8'b1 << idx;
            state   <= ST_RELEASE;
          end
        end
        ST_RELEASE: begin
          // OR-ing req after the clear lets a same-cycle request keep the bit
          pending <= (pending & ~(8'b1 << idx)) | bus.req;
          rr_ptr  <= idx + 3'd1;
          state   <= ST_IDLE;
        end
        default: state <= ST_IDLE;
      endcase
    end
  end

  digit_to_7seg u_seg (
    .digit    (idx),
    .segments (seg_raw)
  );

  assign bus.grant       = grant_q;
  assign bus.grant_valid = gv_q;
  assign bus.ack         = ack_q;
  assign bus.segments    = gv_q ? seg_raw : '0;
  assign bus.none        = ~gv_q;

endmodule
